exhaustive_vector_sweeper: RTL

Synthesizable exhaustive-stimulus engine for small combinational blocks under test. On start it walks every N_IN-bit input vector, holds each for DWELL cycles, samples the DUT response and compacts all responses into a MISR signature. It replaces hand-listed vector sequences in lab benches and on-board checks. The DUT sits between vec_out and resp_in.

---
 rtl/exhaustive_vector_sweeper.sv | 116 +++++++++++
 1 files changed

// File: rtl/exhaustive_vector_sweeper.sv
// Exhaustive stimulus engine: walks all 2^N_IN input vectors, samples the DUT response and folds it into a MISR.
// Build option SWEEP_GRAY_EN drives vec_out in Gray order instead of binary order.
module exhaustive_vector_sweeper #(
   parameter int          N_IN   = 4,
   parameter int          DWELL  = 20,
   parameter int          RESP_W = 3,
   parameter int          SIG_W  = 16,
   parameter logic [15:0] POLY   = 16'h1021
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [RESP_W-1:0] resp_in,
   output logic [N_IN-1:0]   vec_out,
   output logic              vec_valid,
   output logic [N_IN-1:0]   vec_idx,
   output logic              sample_stb,
   output logic              busy,
   output logic              done,
   output logic [SIG_W-1:0]  signature
);

   typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

   localparam int               CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0]    RELOAD   = CW'(DWELL - 1);
   localparam logic [N_IN-1:0]  LAST_IDX = '1;
   localparam logic [SIG_W-1:0] POLY_S   = SIG_W'(POLY);

   state_t            state;
   logic [CW-1:0]     dwell_cnt;
   logic [N_IN-1:0]   idx_inc;
   logic [SIG_W-1:0]  misr_next;

   // The stimulus is registered so the encoding never glitches on the DUT inputs.
   function automatic logic [N_IN-1:0] encode(input logic [N_IN-1:0] idx);
`ifdef SWEEP_GRAY_EN
      return idx ^ (idx >> 1);
`else
      return idx;
`endif
   endfunction

   always_comb begin
      idx_inc   = vec_idx + N_IN'(1);
      misr_next = {signature[SIG_W-2:0], 1'b0}
                ^ (signature[SIG_W-1] ? POLY_S : '0)
                ^ SIG_W'(resp_in);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         dwell_cnt  <= '0;
         vec_idx    <= '0;
         vec_out    <= '0;
         vec_valid  <= 1'b0;
         sample_stb <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         signature  <= '0;
      end else if (abort) begin
         // Signature is deliberately kept so a partial result stays readable.
         state      <= IDLE;
         dwell_cnt  <= '0;
         vec_idx    <= '0;
         vec_out    <= encode('0);
         vec_valid  <= 1'b0;
         sample_stb <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state      <= APPLY;
                  dwell_cnt  <= RELOAD;
                  vec_idx    <= '0;
                  vec_out    <= encode('0);
                  signature  <= '0;
                  vec_valid  <= 1'b1;
                  sample_stb <= 1'b0;
                  busy       <= 1'b1;
                  done       <= 1'b0;
               end
            end
            APPLY: begin
               if (dwell_cnt == '0) begin
                  state      <= SAMPLE;
                  sample_stb <= 1'b1;
               end else begin
                  dwell_cnt <= dwell_cnt - CW'(1);
               end
            end
            SAMPLE: begin
               sample_stb <= 1'b0;
               signature  <= misr_next;
               if (vec_idx == LAST_IDX) begin
                  state     <= DONE;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  vec_valid <= 1'b0;
               end else begin
                  state     <= APPLY;
                  vec_idx   <= idx_inc;
                  vec_out   <= encode(idx_inc);
                  dwell_cnt <= RELOAD;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
